// File: rtl/req_queue.sv
// Request queue between the request arbiter and the tag-lookup stage; DEPTH-entry FIFO.
// Latency: 1 cycle push-to-head, no same-cycle bypass from input to output.
// Backpressure: in_req_rdy = !full && !flush from registered state; independent of out_req_rdy.
//
// Ports:
//   clk, rst          - sole clock, asynchronous active-high reset
//   in_req_vld/rdy/pld  - arbitrated request from the arbiter
//   out_req_vld/rdy/pld - head entry toward tag lookup
//   flush             - synchronous discard of all queued entries
//   count             - number of valid entries (0..DEPTH)
module req_queue #(
    parameter int  DEPTH    = 4,
    parameter type PLD_TYPE = logic
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_req_vld,
    output logic                    in_req_rdy,
    input  PLD_TYPE                 in_req_pld,
    output logic                    out_req_vld,
    input  logic                    out_req_rdy,
    output PLD_TYPE                 out_req_pld,
    input  logic                    flush,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    PLD_TYPE       mem [DEPTH];

    logic empty;
    logic full;
    logic push;
    logic pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    // A pop in the full cycle does not open the input until the next cycle,
    // keeping in_req_rdy free of any path from out_req_rdy.
    assign in_req_rdy  = !full && !flush;
    assign out_req_vld = !empty && !flush;
    assign out_req_pld = mem[rd_ptr[AW-1:0]];

    assign push = in_req_vld && in_req_rdy;
    assign pop  = out_req_vld && out_req_rdy;

    // Occupancy follows from the pointer difference; modular subtraction handles wrap.
    assign count = wr_ptr - rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Payload storage is not reset; only entries between the pointers are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= in_req_pld;
        end
    end

endmodule

// File: tb/tb_req_queue.sv
module tb_req_queue;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_req_vld;
    logic       in_req_rdy;
    logic [7:0] in_req_pld;
    logic       out_req_vld;
    logic       out_req_rdy;
    logic [7:0] out_req_pld;
    logic       flush;
    logic [2:0] count;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q [$];

    req_queue #(.DEPTH(4), .PLD_TYPE(logic [7:0])) dut (
        .clk         (clk),
        .rst         (rst),
        .in_req_vld  (in_req_vld),
        .in_req_rdy  (in_req_rdy),
        .in_req_pld  (in_req_pld),
        .out_req_vld (out_req_vld),
        .out_req_rdy (out_req_rdy),
        .out_req_pld (out_req_pld),
        .flush       (flush),
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [7:0] d);
        in_req_vld = 1'b1;
        in_req_pld = d;
        exp_q.push_back(d);
        tick();
        in_req_vld = 1'b0;
    endtask

    // Monitor: whenever a head entry is presented it must match the scoreboard
    // head; when it is also accepted the scoreboard entry is retired.
    always @(negedge clk) begin
        if (!rst && out_req_vld) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_vld: got pld %0d expected no output", out_req_pld);
            end else begin
                chk("head_pld", int'(out_req_pld), int'(exp_q[0]));
                if (out_req_rdy) begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        in_req_vld  = 1'b0;
        in_req_pld  = 8'h00;
        out_req_rdy = 1'b0;
        flush       = 1'b0;
        tick();
        tick();
        chk("rst_in_rdy", int'(in_req_rdy), 1);
        chk("rst_out_vld", int'(out_req_vld), 0);
        chk("rst_count", int'(count), 0);
        rst = 1'b0;
        tick();

        // Basic flow: push A, present after one edge, then pop.
        in_req_vld = 1'b1;
        in_req_pld = 8'hA1;
        exp_q.push_back(8'hA1);
        #1;
        chk("no_bypass_vld", int'(out_req_vld), 0);
        tick();
        in_req_vld = 1'b0;
        chk("basic_vld", int'(out_req_vld), 1);
        chk("basic_pld", int'(out_req_pld), 8'hA1);
        chk("basic_count1", int'(count), 1);
        out_req_rdy = 1'b1;
        tick();
        chk("basic_count0", int'(count), 0);
        chk("basic_vld0", int'(out_req_vld), 0);
        out_req_rdy = 1'b0;

        // Fill to full; fifth request refused; drain in order.
        for (int i = 0; i < 4; i++) push_one(8'hB0 + 8'(i));
        in_req_vld = 1'b1;
        in_req_pld = 8'hEE;
        #1;
        chk("fill_count", int'(count), 4);
        chk("fill_in_rdy", int'(in_req_rdy), 0);
        tick();
        chk("fill_refused_count", int'(count), 4);
        in_req_vld  = 1'b0;
        out_req_rdy = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("drain_count", int'(count), 0);
        out_req_rdy = 1'b0;

        // Full with simultaneous pop: only the pop happens.
        for (int i = 0; i < 4; i++) push_one(8'hC0 + 8'(i));
        in_req_vld  = 1'b1;
        in_req_pld  = 8'hCC;
        out_req_rdy = 1'b1;
        #1;
        chk("fullpop_in_rdy_before", int'(in_req_rdy), 0);
        tick();
        chk("fullpop_count", int'(count), 3);
        chk("fullpop_in_rdy_after", int'(in_req_rdy), 1);
        in_req_vld = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("fullpop_drain", int'(count), 0);
        out_req_rdy = 1'b0;

        // Wrap-around: hold occupancy at 2 across many push/pop pairs.
        push_one(8'hD0);
        push_one(8'hD1);
        out_req_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_req_vld = 1'b1;
            in_req_pld = 8'hE0 + 8'(i);
            exp_q.push_back(8'hE0 + 8'(i));
            tick();
            chk("wrap_count", int'(count), 2);
        end
        in_req_vld = 1'b0;
        tick();
        tick();
        chk("wrap_drain", int'(count), 0);
        out_req_rdy = 1'b0;

        // Flush with push and pop requested: neither happens.
        for (int i = 0; i < 3; i++) push_one(8'hF0 + 8'(i));
        chk("preflush_count", int'(count), 3);
        flush       = 1'b1;
        in_req_vld  = 1'b1;
        in_req_pld  = 8'h99;
        out_req_rdy = 1'b1;
        exp_q.delete();
        #1;
        chk("flush_out_vld", int'(out_req_vld), 0);
        chk("flush_in_rdy", int'(in_req_rdy), 0);
        tick();
        flush       = 1'b0;
        in_req_vld  = 1'b0;
        out_req_rdy = 1'b0;
        #1;
        chk("postflush_count", int'(count), 0);
        chk("postflush_vld", int'(out_req_vld), 0);
        push_one(8'h5A);
        chk("postflush_push", int'(count), 1);
        out_req_rdy = 1'b1;
        tick();
        out_req_rdy = 1'b0;
        chk("postflush_drain", int'(count), 0);

        // Async reset mid-operation.
        push_one(8'h60);
        push_one(8'h61);
        chk("prerst_count", int'(count), 2);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("arst_vld", int'(out_req_vld), 0);
        chk("arst_count", int'(count), 0);
        chk("arst_in_rdy", int'(in_req_rdy), 1);
        in_req_vld = 1'b1;
        in_req_pld = 8'h77;
        tick();
        chk("rst_edge_no_push", int'(count), 0);
        rst = 1'b0;
        push_one(8'h42);
        chk("after_rst_count", int'(count), 1);
        chk("after_rst_pld", int'(out_req_pld), 8'h42);
        out_req_rdy = 1'b1;
        tick();
        out_req_rdy = 1'b0;
        chk("after_rst_drain", int'(count), 0);

        tick();
        tick();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
